// File: rtl/control_step_sequencer_pkg.sv
// Shared types and constants for the micro-step control sequencer: state encoding,
// bus source codes (also used by the bus-select encoder), opcodes and IR field positions.
package control_step_sequencer_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT1w  = 4'd3,
    StT2   = 4'd4,
    StT3   = 4'd5,
    StT4   = 4'd6,
    StT5   = 4'd7,
    StT6   = 4'd8,
    StDone = 4'd9
  } state_e;

  localparam int unsigned SRC_W       = 24;
  localparam int unsigned SRC_R0      = 0;
  localparam int unsigned SRC_HI      = 16;
  localparam int unsigned SRC_LO      = 17;
  localparam int unsigned SRC_ZHIGH   = 18;
  localparam int unsigned SRC_ZLOW    = 19;
  localparam int unsigned SRC_PC      = 20;
  localparam int unsigned SRC_MDR     = 21;
  localparam int unsigned SRC_IN_PORT = 22;
  localparam int unsigned SRC_C       = 23;

  localparam logic [4:0] OP_ALU_LAST = 5'h0B;
  localparam logic [4:0] OP_MUL      = 5'h0F;
  localparam logic [4:0] OP_DIV      = 5'h10;

  localparam int unsigned IR_OP_MSB = 31;
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_MSB = 26;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_MSB = 22;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_MSB = 18;
  localparam int unsigned IR_RC_LSB = 15;

  function automatic logic [SRC_W-1:0] src_bit(input int unsigned idx);
    return SRC_W'(1) << idx;
  endfunction

endpackage

// File: rtl/control_step_sequencer_if.sv
// Bundle of sequencer inputs (run, IR, memory ready) and all strobe/enable outputs.
interface control_step_sequencer_if #(
  parameter int unsigned ALU_OP_W = 5
);
  logic                run;
  logic [31:0]         ir;
  logic                mem_ready;
  logic [23:0]         src_out;
  logic [15:0]         gpr_in;
  logic                pc_in;
  logic                mar_in;
  logic                mdr_in;
  logic                ir_in;
  logic                y_in;
  logic                z_in;
  logic                hi_in;
  logic                lo_in;
  logic                inc_pc;
  logic                mem_read;
  logic [ALU_OP_W-1:0] alu_op;
  logic [3:0]          step;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  run, ir, mem_ready,
    output src_out, gpr_in, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
           inc_pc, mem_read, alu_op, step, busy, done, err
  );

  modport slave (
    output run, ir, mem_ready,
    input  src_out, gpr_in, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
           inc_pc, mem_read, alu_op, step, busy, done, err
  );
endinterface

// File: rtl/control_step_sequencer_ir_decode.sv
// Combinational IR decode: opcode class and one-hot register selects.
module control_step_sequencer_ir_decode
  import control_step_sequencer_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [4:0]  opcode_o,
  output logic [15:0] ra_oh_o,
  output logic [15:0] rb_oh_o,
  output logic [15:0] rc_oh_o,
  output logic        is_alu_o,
  output logic        is_muldiv_o,
  output logic        illegal_o
);

  assign opcode_o    = ir_i[IR_OP_MSB:IR_OP_LSB];
  assign ra_oh_o     = 16'd1 << ir_i[IR_RA_MSB:IR_RA_LSB];
  assign rb_oh_o     = 16'd1 << ir_i[IR_RB_MSB:IR_RB_LSB];
  assign rc_oh_o     = 16'd1 << ir_i[IR_RC_MSB:IR_RC_LSB];
  assign is_alu_o    = (opcode_o <= OP_ALU_LAST);
  assign is_muldiv_o = (opcode_o == OP_MUL) || (opcode_o == OP_DIV);
  assign illegal_o   = !(is_alu_o || is_muldiv_o);

endmodule

// File: rtl/control_step_sequencer.sv
// Micro-step control FSM: fetch then execute, one bus source strobe per cycle at most.
module control_step_sequencer
  import control_step_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned ALU_OP_W    = 5
) (
  input logic                    clk,
  input logic                    clr,
  control_step_sequencer_if.master bus_io
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW:0]   cnt_inc;
  logic            err_q, err_d;
  logic            timeout;

  logic [4:0]  opcode;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        is_alu, is_muldiv, illegal;

  control_step_sequencer_ir_decode u_ir_decode (
    .ir_i        (bus_io.ir),
    .opcode_o    (opcode),
    .ra_oh_o     (ra_oh),
    .rb_oh_o     (rb_oh),
    .rc_oh_o     (rc_oh),
    .is_alu_o    (is_alu),
    .is_muldiv_o (is_muldiv),
    .illegal_o   (illegal)
  );

  assign cnt_inc = {1'b0, cnt_q} + (CntW + 1)'(1);
  // MEM_TIMEOUT of zero disables the limit; the counter then just wraps harmlessly.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_inc == (CntW + 1)'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: if (bus_io.run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   state_d = StT1w;
      StT1w: begin
        if (bus_io.mem_ready) begin
          state_d = StT2;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc[CntW-1:0];
        end
      end
      StT2:   state_d = StT3;
      StT3:   state_d = illegal ? StDone : StT4;
      StT4:   state_d = StT5;
      StT5:   state_d = is_muldiv ? StT6 : StDone;
      StT6:   state_d = StDone;
      StDone: state_d = bus_io.run ? StT0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic [SRC_W-1:0]    src_out;
  logic [15:0]         gpr_in;
  logic                pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
  logic                inc_pc, mem_read, done;
  logic [ALU_OP_W-1:0] alu_op;

  always_comb begin
    src_out  = '0;
    gpr_in   = '0;
    pc_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    hi_in    = 1'b0;
    lo_in    = 1'b0;
    inc_pc   = 1'b0;
    mem_read = 1'b0;
    alu_op   = '0;
    done     = 1'b0;
    case (state_q)
      StT0: begin
        src_out = src_bit(SRC_PC);
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
      end
      StT1: begin
        src_out = src_bit(SRC_ZLOW);
        pc_in   = 1'b1;
      end
      StT1w: begin
        mem_read = 1'b1;
        mdr_in   = bus_io.mem_ready;
      end
      StT2: begin
        src_out = src_bit(SRC_MDR);
        ir_in   = 1'b1;
      end
      StT3: begin
        // Illegal opcodes behave as a NOP: no transfer, no load.
        if (!illegal) begin
          src_out = {{(SRC_W - 16){1'b0}}, rb_oh};
          y_in    = 1'b1;
        end
      end
      StT4: begin
        src_out = {{(SRC_W - 16){1'b0}}, rc_oh};
        z_in    = 1'b1;
        alu_op  = ALU_OP_W'(opcode);
      end
      StT5: begin
        src_out = src_bit(SRC_ZLOW);
        if (is_muldiv) lo_in = 1'b1;
        else if (is_alu) gpr_in = ra_oh;
      end
      StT6: begin
        src_out = src_bit(SRC_ZHIGH);
        hi_in   = 1'b1;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.src_out  = src_out;
  assign bus_io.gpr_in   = gpr_in;
  assign bus_io.pc_in    = pc_in;
  assign bus_io.mar_in   = mar_in;
  assign bus_io.mdr_in   = mdr_in;
  assign bus_io.ir_in    = ir_in;
  assign bus_io.y_in     = y_in;
  assign bus_io.z_in     = z_in;
  assign bus_io.hi_in    = hi_in;
  assign bus_io.lo_in    = lo_in;
  assign bus_io.inc_pc   = inc_pc;
  assign bus_io.mem_read = mem_read;
  assign bus_io.alu_op   = alu_op;
  assign bus_io.step     = state_q;
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.done     = done;
  assign bus_io.err      = err_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench: per-cycle expected outputs queued and compared at the falling edge.
module tb_control_step_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  control_step_sequencer_if #(.ALU_OP_W(5)) bus ();

  control_step_sequencer #(
    .MEM_TIMEOUT (4),
    .ALU_OP_W    (5)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .bus_io (bus.master)
  );

  typedef struct packed {
    logic [3:0]  step;
    logic [23:0] src;
    logic [15:0] gpr;
    logic [9:0]  en;
    logic [4:0]  alu;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  // en = {pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read}
  localparam logic [9:0] E_PC  = 10'h200;
  localparam logic [9:0] E_MAR = 10'h100;
  localparam logic [9:0] E_MDR = 10'h080;
  localparam logic [9:0] E_IR  = 10'h040;
  localparam logic [9:0] E_Y   = 10'h020;
  localparam logic [9:0] E_Z   = 10'h010;
  localparam logic [9:0] E_HI  = 10'h008;
  localparam logic [9:0] E_LO  = 10'h004;
  localparam logic [9:0] E_INC = 10'h002;
  localparam logic [9:0] E_RD  = 10'h001;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic err_exp;

  function automatic exp_t mk(input logic [3:0] st, input int src, input logic [15:0] gpr,
                              input logic [9:0] en, input logic [4:0] alu, input logic dn);
    exp_t e;
    e.step = st;
    e.src  = (src < 0) ? 24'd0 : (24'd1 << src);
    e.gpr  = gpr;
    e.en   = en;
    e.alu  = alu;
    e.busy = (st != 4'd0);
    e.done = dn;
    e.err  = err_exp;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t a;
    a.step = bus.step;
    a.src  = bus.src_out;
    a.gpr  = bus.gpr_in;
    a.en   = {bus.pc_in, bus.mar_in, bus.mdr_in, bus.ir_in, bus.y_in, bus.z_in,
              bus.hi_in, bus.lo_in, bus.inc_pc, bus.mem_read};
    a.alu  = bus.alu_op;
    a.busy = bus.busy;
    a.done = bus.done;
    a.err  = bus.err;
    return a;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    exp_t a;
    e = sb.pop_front();
    a = observe();
    n_chk++;
    assert (a === e) n_pass++;
    else $error("FAIL %s: got step=%0d src=%h gpr=%h en=%h alu=%h busy=%b done=%b err=%b, expected step=%0d src=%h gpr=%h en=%h alu=%h busy=%b done=%b err=%b",
                tag, a.step, a.src, a.gpr, a.en, a.alu, a.busy, a.done, a.err,
                e.step, e.src, e.gpr, e.en, e.alu, e.busy, e.done, e.err);
    n_chk++;
    assert ($countones(bus.src_out) <= 1 && $countones(bus.gpr_in) <= 1) n_pass++;
    else $error("FAIL onehot_%s: src_out=%h gpr_in=%h, expected at most one bit each",
                tag, bus.src_out, bus.gpr_in);
  endtask

  task automatic tick(input string tag, input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string pfx, input int waits, input logic run_t2);
    tick({pfx, "_t0"}, mk(4'd1, 20, 16'h0, E_MAR | E_INC | E_Z, 5'h0, 1'b0));
    tick({pfx, "_t1"}, mk(4'd2, 19, 16'h0, E_PC, 5'h0, 1'b0));
    for (int i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      tick({pfx, "_t1w_wait"}, mk(4'd3, -1, 16'h0, E_RD, 5'h0, 1'b0));
    end
    bus.mem_ready = 1'b1;
    tick({pfx, "_t1w"}, mk(4'd3, -1, 16'h0, E_RD | E_MDR, 5'h0, 1'b0));
    bus.run = run_t2;
    tick({pfx, "_t2"}, mk(4'd4, 21, 16'h0, E_IR, 5'h0, 1'b0));
  endtask

  localparam logic [31:0] IR_ADD = 32'h0189_0000;  // ADD R3,R1,R2
  localparam logic [31:0] IR_MUL = {5'h0F, 4'd9, 4'd5, 4'd6, 15'd0};
  localparam logic [31:0] IR_R0  = {5'h0B, 4'd0, 4'd0, 4'd0, 15'd0};
  localparam logic [31:0] IR_ILL = {5'h1F, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_OP5 = {5'h05, 4'd2, 4'd3, 4'd4, 15'd0};

  initial begin
    clr           = 1'b1;
    bus.run       = 1'b0;
    bus.ir        = '0;
    bus.mem_ready = 1'b0;
    err_exp       = 1'b0;
    @(posedge clk);
    #1;
    tick("reset", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    clr = 1'b0;

    // ADD R3,R1,R2, memory ready immediately
    bus.run       = 1'b1;
    bus.ir        = IR_ADD;
    bus.mem_ready = 1'b1;
    tick("add_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    fetch("add", 0, 1'b1);
    tick("add_t3", mk(4'd5, 1, 16'h0, E_Y, 5'h0, 1'b0));
    tick("add_t4", mk(4'd6, 2, 16'h0, E_Z, 5'h00, 1'b0));
    tick("add_t5", mk(4'd7, 19, 16'h0008, 10'h0, 5'h0, 1'b0));
    tick("add_done", mk(4'd9, -1, 16'h0, 10'h0, 5'h0, 1'b1));

    // MUL R5,R6 straight after, run still high
    bus.ir = IR_MUL;
    fetch("mul", 0, 1'b1);
    tick("mul_t3", mk(4'd5, 5, 16'h0, E_Y, 5'h0, 1'b0));
    tick("mul_t4", mk(4'd6, 6, 16'h0, E_Z, 5'h0F, 1'b0));
    tick("mul_t5", mk(4'd7, 19, 16'h0, E_LO, 5'h0, 1'b0));
    tick("mul_t6", mk(4'd8, 18, 16'h0, E_HI, 5'h0, 1'b0));
    tick("mul_done", mk(4'd9, -1, 16'h0, 10'h0, 5'h0, 1'b1));

    // R0 <- R0 op R0 with three wait cycles; run drops during T2
    bus.ir = IR_R0;
    fetch("wait", 3, 1'b0);
    tick("wait_t3", mk(4'd5, 0, 16'h0, E_Y, 5'h0, 1'b0));
    tick("wait_t4", mk(4'd6, 0, 16'h0, E_Z, 5'h0B, 1'b0));
    tick("wait_t5", mk(4'd7, 19, 16'h0001, 10'h0, 5'h0, 1'b0));
    tick("wait_done", mk(4'd9, -1, 16'h0, 10'h0, 5'h0, 1'b1));
    tick("wait_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    tick("wait_idle2", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));

    // Illegal opcode: T3 then DONE, then straight into the next fetch
    bus.ir  = IR_ILL;
    bus.run = 1'b1;
    tick("ill_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    fetch("ill", 0, 1'b1);
    tick("ill_t3", mk(4'd5, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    tick("ill_done", mk(4'd9, -1, 16'h0, 10'h0, 5'h0, 1'b1));

    // clr asserted mid-T4 clears outputs without a clock edge
    bus.ir = IR_OP5;
    fetch("clr", 0, 1'b1);
    tick("clr_t3", mk(4'd5, 3, 16'h0, E_Y, 5'h0, 1'b0));
    sb.push_back(mk(4'd6, 4, 16'h0, E_Z, 5'h05, 1'b0));
    @(negedge clk);
    check("clr_t4");
    clr = 1'b1;
    #1;
    sb.push_back(mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    check("clr_async");
    @(posedge clk);
    #1;
    clr     = 1'b0;
    bus.run = 1'b0;
    tick("clr_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));

    // Memory never ready: four wait cycles then timeout to IDLE with sticky err
    bus.run       = 1'b1;
    bus.mem_ready = 1'b0;
    tick("to_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    tick("to_t0", mk(4'd1, 20, 16'h0, E_MAR | E_INC | E_Z, 5'h0, 1'b0));
    tick("to_t1", mk(4'd2, 19, 16'h0, E_PC, 5'h0, 1'b0));
    for (int i = 0; i < 4; i++) tick("to_t1w", mk(4'd3, -1, 16'h0, E_RD, 5'h0, 1'b0));
    err_exp = 1'b1;
    bus.run = 1'b0;
    tick("to_err", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    tick("to_err_hold", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));

    // err survives a normal instruction, cleared only by clr
    bus.run = 1'b1;
    bus.ir  = IR_ADD;
    tick("sticky_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    fetch("sticky", 0, 1'b1);
    tick("sticky_t3", mk(4'd5, 1, 16'h0, E_Y, 5'h0, 1'b0));
    tick("sticky_t4", mk(4'd6, 2, 16'h0, E_Z, 5'h00, 1'b0));
    tick("sticky_t5", mk(4'd7, 19, 16'h0008, 10'h0, 5'h0, 1'b0));
    bus.run = 1'b0;
    tick("sticky_done", mk(4'd9, -1, 16'h0, 10'h0, 5'h0, 1'b1));
    tick("sticky_idle2", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    clr     = 1'b1;
    err_exp = 1'b0;
    tick("err_clr", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));
    clr = 1'b0;
    tick("err_clr_idle", mk(4'd0, -1, 16'h0, 10'h0, 5'h0, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
